bidir_piso_tx: RTL and testbench

BIDIR_PISO_TX -- requirements
Module: bidir_piso_tx

---
 rtl/bidir_piso_tx.sv | 123 ++++++++++++
 tb/tb_bidir_piso_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/bidir_piso_tx.sv
// Parallel-in serial-out transmitter with a per-frame selectable bit order.
// A word is accepted in IDLE, shifted out over WIDTH enabled cycles in SHIFT, then DONE pulses once.
module bidir_piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             direction,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;

  // State, shift register, bit counter and latched bit order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic: accept in IDLE, shift on en, single-cycle DONE.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (load_valid) begin
          sr_d    = load_data;
          dir_d   = direction;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          // Shift toward whichever end is being presented on s_out.
          if (dir_q) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
          end else begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; all forced low while rst is asserted.
  always_comb begin
    load_ready = 1'b0;
    s_out      = 1'b0;
    s_valid    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          load_ready = 1'b1;
        end
        ST_SHIFT: begin
          s_out   = dir_q ? sr_q[WIDTH-1] : sr_q[0];
          s_valid = en;
          busy    = 1'b1;
        end
        ST_DONE: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: begin
          load_ready = 1'b0;
        end
      endcase
    end else begin
      load_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_bidir_piso_tx.sv
// Self-checking bench for bidir_piso_tx: directed scenarios plus random traffic
// against a frame-level reference model (queue of pending bits) and a loopback receiver.
module tb_bidir_piso_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data = '0;
  logic         direction = 1'b0;
  logic         s_out;
  logic         s_valid;
  logic         busy;
  logic         done;

  bidir_piso_tx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .direction  (direction),
    .s_out      (s_out),
    .s_valid    (s_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 shifting, 2 done; bits still to send.
  int           m_phase = 0;
  logic         m_bits[$];
  logic [W-1:0] m_data = '0;
  logic         m_dir = 1'b0;
  logic [W-1:0] rx = '0;
  int           cyc = 0;
  int           last_acc = 0;
  bit           have_prev = 1'b0;
  bit           chk_spacing = 1'b0;
  int           n_done = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic lv,
                      input logic [W-1:0] d, input logic dr);
    logic [4:0] exp_o;
    rst = r; en = e; load_valid = lv; load_data = d; direction = dr;
    @(negedge clk);
    // Expected {load_ready, s_out, s_valid, busy, done}.
    if (r)                exp_o = 5'b00000;
    else if (m_phase == 0) exp_o = 5'b10000;
    else if (m_phase == 1) exp_o = {1'b0, m_bits[0], e, 1'b1, 1'b0};
    else                  exp_o = 5'b00011;
    check_val("outputs", {27'd0, load_ready, s_out, s_valid, busy, done}, {27'd0, exp_o});

    if (!r && m_phase == 1 && s_valid)
      rx = m_dir ? {rx[W-2:0], s_out} : {s_out, rx[W-1:1]};
    if (!r && m_phase == 2) begin
      check_val("rx_word", {24'd0, rx}, {24'd0, m_data});
      n_done++;
    end
    if (!r && load_ready && lv) begin
      if (chk_spacing && have_prev) check_val("accept_spacing", cyc - last_acc, W + 2);
      last_acc = cyc;
      have_prev = 1'b1;
    end

    if (r) begin
      m_phase = 0;
      m_bits.delete();
    end else begin
      case (m_phase)
        0: if (lv) begin
          m_bits.delete();
          for (int i = 0; i < W; i++) m_bits.push_back(dr ? d[W-1-i] : d[i]);
          m_data = d; m_dir = dr; rx = '0; m_phase = 1;
        end
        1: if (e) begin
          void'(m_bits.pop_front());
          if (m_bits.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input logic dr);
    step(1'b0, 1'b1, 1'b1, d, dr);
    repeat (W + 1) step(1'b0, 1'b1, 1'b0, W'($urandom), 1'(~dr));
  endtask

  initial begin
    int d0;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);

    // Idle right after release, en toggling must not matter.
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);

    d0 = n_done;
    send(8'hA5, 1'b0);
    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    check_val("done_count", n_done - d0, 3);

    // en gaps: two bits, three frozen cycles, then the rest.
    step(1'b0, 1'b1, 1'b1, 8'h66, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1);
    repeat (W - 1) step(1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Back-pressure: load_valid held high, inputs churning mid-frame.
    have_prev = 1'b0;
    chk_spacing = 1'b1;
    repeat (4 * (W + 2)) step(1'b0, 1'b1, 1'b1, W'($urandom), 1'($urandom));
    chk_spacing = 1'b0;
    repeat (W + 2) step(1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Reset mid-frame after the third bit, then a clean frame.
    d0 = n_done;
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    check_val("no_done_after_abort", n_done - d0, 0);
    send(8'h01, 1'b0);
    send(8'h01, 1'b1);

    // Random traffic with sparse resets.
    repeat (600)
      step(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), W'($urandom), 1'($urandom));
    repeat (2 * W + 4) step(1'b0, 1'b1, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
